// File: rtl/ula_muldiv.sv
// ula_muldiv: iterative unsigned multiply / divide unit for the ALU.
// Multiply is shift-add and divide is restoring. Each produces one bit per
// cycle, so an operation takes TAM cycles. A divide by zero finishes after
// a single cycle.
//
// Ports:
//   CLK              clock; all state changes on its rising edge
//   RST_N            asynchronous active-low reset
//   A_ULA            multiplicand / dividend (TAM bits)
//   B_ULA            multiplier / divisor (TAM bits)
//   MD_start         start request; accepted in IDLE or DONE only
//   MD_op            0 = unsigned multiply, 1 = unsigned divide
//   MD_busy          high while iterating (RUN)
//   MD_done          one-cycle pulse; results are valid from this cycle on
//   MD_hi            product high half / remainder
//   MD_lo            product low half / quotient
//   MD_div0          divide-by-zero flag; held until the next accepted start
module ula_muldiv #(
  parameter int TAM = 16
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [TAM-1:0] A_ULA,
  input  logic [TAM-1:0] B_ULA,
  input  logic           MD_start,
  input  logic           MD_op,
  output logic           MD_busy,
  output logic           MD_done,
  output logic [TAM-1:0] MD_hi,
  output logic [TAM-1:0] MD_lo,
  output logic           MD_div0
);

  localparam int CW = $clog2(TAM + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_nx_s;
  logic [CW-1:0]  cnt_r;
  logic [TAM-1:0] a_r, b_r;
  logic           op_r;
  logic [TAM-1:0] work_hi_r, work_lo_r;
  logic [TAM-1:0] hi_r, lo_r;
  logic           div0_r, busy_r, done_r;
  logic           busy_nx_s, done_nx_s;
  logic           accept_s, last_s, b_zero_s;
  logic [TAM:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [TAM-1:0] step_hi_s, step_lo_s;

  assign accept_s = MD_start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s   = (cnt_r == CW'(TAM - 1));
  assign b_zero_s = (b_r == {TAM{1'b0}});

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE: begin
        if (MD_start) state_nx_s = RUN;
        else          state_nx_s = IDLE;
      end
      RUN: begin
        // A zero divisor skips the iterations entirely.
        if (op_r && b_zero_s) state_nx_s = DONE;
        else if (last_s)      state_nx_s = DONE;
        else                  state_nx_s = RUN;
      end
      DONE: begin
        // A start in the DONE cycle chains straight into the next operation.
        if (MD_start) state_nx_s = RUN;
        else          state_nx_s = IDLE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode. The flags are registered, so they follow the next state.
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_nx_s)
      RUN:     busy_nx_s = 1'b1;
      DONE:    done_nx_s = 1'b1;
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Status flag registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
    end
  end

  // One iteration step, shared by both algorithms.
  // Multiply: {work_hi, work_lo} is the partial product, and work_lo starts
  //   as the multiplier. Each step adds A when the LSB is set, then shifts
  //   the whole pair right. The carry of the add comes back in at the top.
  // Divide: work_hi is the partial remainder and work_lo starts as the
  //   dividend. Each step shifts one dividend bit into the remainder and
  //   tries to subtract B. A clear sign bit means the subtraction fits.
  always_comb begin
    mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, a_r} : {(TAM+1){1'b0}});
    div_shift_s = {work_hi_r, work_lo_r[TAM-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (op_r == 1'b0) begin
      step_hi_s = mul_sum_s[TAM:1];
      step_lo_s = {mul_sum_s[0], work_lo_r[TAM-1:1]};
    end else if (div_diff_s[TAM] == 1'b0) begin
      step_hi_s = div_diff_s[TAM-1:0];
      step_lo_s = {work_lo_r[TAM-2:0], 1'b1};
    end else begin
      step_hi_s = div_shift_s[TAM-1:0];
      step_lo_s = {work_lo_r[TAM-2:0], 1'b0};
    end
  end

  // Operand capture, iteration, and result load on entry to DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_r       <= {TAM{1'b0}};
      b_r       <= {TAM{1'b0}};
      op_r      <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      work_hi_r <= {TAM{1'b0}};
      work_lo_r <= {TAM{1'b0}};
      hi_r      <= {TAM{1'b0}};
      lo_r      <= {TAM{1'b0}};
      div0_r    <= 1'b0;
    end else if (accept_s) begin
      a_r       <= A_ULA;
      b_r       <= B_ULA;
      op_r      <= MD_op;
      cnt_r     <= {CW{1'b0}};
      work_hi_r <= {TAM{1'b0}};
      work_lo_r <= MD_op ? A_ULA : B_ULA;
      div0_r    <= 1'b0;
    end else if (state_r == RUN) begin
      if (op_r && b_zero_s) begin
        hi_r   <= a_r;
        lo_r   <= {TAM{1'b1}};
        div0_r <= 1'b1;
      end else begin
        work_hi_r <= step_hi_s;
        work_lo_r <= step_lo_s;
        cnt_r     <= cnt_r + CW'(1);
        if (last_s) begin
          hi_r <= step_hi_s;
          lo_r <= step_lo_s;
        end
      end
    end
  end

  assign MD_busy = busy_r;
  assign MD_done = done_r;
  assign MD_hi   = hi_r;
  assign MD_lo   = lo_r;
  assign MD_div0 = div0_r;

endmodule

// File: tb/tb_ula_muldiv.sv
// Scoreboard bench for ula_muldiv. The stimulus pushes the expected results
// and the completion cycle. The monitor pops one entry on every MD_done
// pulse and compares it.
module tb_ula_muldiv;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] A_ULA, B_ULA;
  logic        MD_start, MD_op;
  logic        MD_busy, MD_done, MD_div0;
  logic [15:0] MD_hi, MD_lo;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        div0;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ula_muldiv #(.TAM(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .A_ULA(A_ULA), .B_ULA(B_ULA),
    .MD_start(MD_start), .MD_op(MD_op), .MD_busy(MD_busy), .MD_done(MD_done),
    .MD_hi(MD_hi), .MD_lo(MD_lo), .MD_div0(MD_div0)
  );

  always #5 CLK = ~CLK;

  // Count rising edges.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Drive a one-cycle start from a negedge. Optionally push the expectation.
  task automatic issue(input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] hi, input logic [15:0] lo, input logic d0,
                       input int lat, input bit push);
    exp_t e;
    MD_op    = op;
    A_ULA    = a;
    B_ULA    = b;
    MD_start = 1'b1;
    if (push) begin
      e.hi   = hi;
      e.lo   = lo;
      e.div0 = d0;
      e.cyc  = cyc + 1 + lat;
      sb_q.push_back(e);
    end
    @(negedge CLK);
    MD_start = 1'b0;
  endtask

  // Monitor: check each done pulse against the oldest expectation.
  always @(negedge CLK) begin
    if (MD_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("md_hi", {16'h0, MD_hi}, {16'h0, e.hi});
        chk("md_lo", {16'h0, MD_lo}, {16'h0, e.lo});
        chk("md_div0", {31'h0, MD_div0}, {31'h0, e.div0});
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  logic        v_op [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] v_a  [6] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h0005, 16'hFFFF, 16'h8000};
  logic [15:0] v_b  [6] = '{16'h5678, 16'hABCD, 16'h0001, 16'h0009, 16'hFFFF, 16'h0002};
  logic [15:0] v_hi [6] = '{16'h0626, 16'h0000, 16'h0000, 16'h0005, 16'h0000, 16'h0001};
  logic [15:0] v_lo [6] = '{16'h0060, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000};

  initial begin
    int bcount;
    RST_N    = 1'b0;
    MD_start = 1'b0;
    MD_op    = 1'b0;
    A_ULA    = 16'h0000;
    B_ULA    = 16'h0000;
    #12;
    chk("rst_outputs", {MD_busy, MD_done, MD_div0, MD_hi, MD_lo}, 35'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // FFFF * FFFF, including the length of the busy window.
    issue(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 16, 1'b1);
    bcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (MD_done === 1'b1) break;
      if (MD_busy === 1'b1) bcount++;
      @(negedge CLK);
    end
    chk("busy_cycles", 32'(bcount), 32'd16);
    @(negedge CLK);

    // 100 / 7.
    issue(1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 16, 1'b1);
    repeat (18) @(negedge CLK);

    // Divide by zero; the flag holds, then a new start clears it.
    issue(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1, 1'b1);
    repeat (3) @(negedge CLK);
    chk("div0_held", {31'h0, MD_div0}, 32'd1);
    issue(1'b0, 16'h0002, 16'h0003, 16'h0000, 16'h0006, 1'b0, 16, 1'b1);
    chk("div0_cleared", {31'h0, MD_div0}, 32'd0);
    repeat (17) @(negedge CLK);

    // Table of additional directed vectors.
    for (int i = 0; i < 6; i++) begin
      issue(v_op[i], v_a[i], v_b[i], v_hi[i], v_lo[i], 1'b0, 16, 1'b1);
      repeat (17) @(negedge CLK);
    end

    // A second start while busy must be ignored.
    issue(1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 16, 1'b1);
    repeat (2) @(negedge CLK);
    issue(1'b1, 16'h0999, 16'h0003, 16'h0000, 16'h0000, 1'b0, 16, 1'b0);
    repeat (25) @(negedge CLK);
    chk("busy_ignore_pending", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of RUN: outputs drop at once and no done follows.
    issue(1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'h0000, 1'b0, 16, 1'b0);
    repeat (7) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_run", {MD_busy, MD_done, MD_div0, MD_hi, MD_lo}, 35'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);

    // Back to back: start the divide in the DONE cycle of 6*7.
    issue(1'b0, 16'h0006, 16'h0007, 16'h0000, 16'h002A, 1'b0, 16, 1'b1);
    repeat (16) @(negedge CLK);
    chk("b2b_done_seen", {31'h0, MD_done}, 32'd1);
    issue(1'b1, 16'd1000, 16'd7, 16'h0006, 16'h008E, 1'b0, 16, 1'b1);
    chk("b2b_busy", {31'h0, MD_busy}, 32'd1);
    repeat (25) @(negedge CLK);
    chk("final_pending", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
